// File: rtl/ivl_uvm_phase_ctrl.sv
// Phase sequencer for a test run: build/connect/run/drain/extract/report/done,
// with per-agent objection counters, drain timer, global watchdog and error tally.
module ivl_uvm_phase_ctrl #(
  parameter int NUM_AGENTS     = 4,
  parameter int DRAIN_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_ERRORS     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_AGENTS-1:0] obj_raise,
  input  logic [NUM_AGENTS-1:0] obj_drop,
  input  logic                  err_pulse,
  output logic [2:0]            phase,
  output logic                  phase_start,
  output logic [NUM_AGENTS-1:0] obj_active,
  output logic [7:0]            err_count,
  output logic                  timeout,
  output logic                  fatal,
  output logic                  done
);

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_BUILD   = 3'd1,
    PH_CONNECT = 3'd2,
    PH_RUN     = 3'd3,
    PH_DRAIN   = 3'd4,
    PH_EXTRACT = 3'd5,
    PH_REPORT  = 3'd6,
    PH_DONE    = 3'd7
  } phase_t;

  localparam logic [31:0] LP_TIMEOUT    = 32'(TIMEOUT_CYCLES);
  localparam logic [15:0] LP_DRAIN_LOAD = 16'(DRAIN_CYCLES - 1);
  localparam logic [7:0]  LP_MAX_ERR    = 8'(MAX_ERRORS);

  phase_t                r_phase;
  phase_t                w_phase_nxt;
  logic                  r_phase_start;
  logic [3:0]            r_cnt     [NUM_AGENTS];
  logic [3:0]            w_cnt_nxt [NUM_AGENTS];
  logic [NUM_AGENTS-1:0] r_obj_active;
  logic [NUM_AGENTS-1:0] w_active_nxt;
  logic [NUM_AGENTS-1:0] w_bad_drop;
  logic [4:0]            w_nbad;
  logic [15:0]           r_drain_left;
  logic [31:0]           r_timer;
  logic [31:0]           w_timer_inc;
  logic [7:0]            r_err;
  logic [7:0]            w_err_nxt;
  logic [9:0]            w_err_sum;
  logic                  r_timeout;
  logic                  r_fatal;
  logic                  r_done;
  logic                  w_in_obj;
  logic                  w_in_err;
  logic                  w_any_raise;
  logic                  w_all_zero_nxt;
  logic                  w_start_ok;
  logic                  w_timeout_hit;
  logic                  w_fatal_hit;

  assign w_in_obj    = (r_phase == PH_RUN) || (r_phase == PH_DRAIN);
  assign w_in_err    = (r_phase >= PH_BUILD) && (r_phase <= PH_REPORT);
  assign w_any_raise = |obj_raise;
  assign w_start_ok  = start && ((r_phase == PH_IDLE) || (r_phase == PH_DONE));
  assign w_timer_inc = r_timer + 32'd1;
  assign w_timeout_hit = w_in_obj && (w_timer_inc >= LP_TIMEOUT);

  // Raise together with drop on the same agent cancels out; a lone drop on an
  // empty counter is reported as an error instead of underflowing.
  always_comb begin
    w_bad_drop   = '0;
    w_active_nxt = '0;
    w_nbad       = '0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_in_obj) begin
        if (obj_raise[i] && !obj_drop[i]) begin
          if (r_cnt[i] != 4'd15) w_cnt_nxt[i] = r_cnt[i] + 4'd1;
        end else if (obj_drop[i] && !obj_raise[i]) begin
          if (r_cnt[i] == 4'd0) w_bad_drop[i] = 1'b1;
          else                  w_cnt_nxt[i] = r_cnt[i] - 4'd1;
        end
      end
      w_active_nxt[i] = (w_cnt_nxt[i] != 4'd0);
      w_nbad = w_nbad + {4'd0, w_bad_drop[i]};
    end
  end

  assign w_all_zero_nxt = ~|w_active_nxt;
  assign w_err_sum = {2'b00, r_err} + {9'd0, err_pulse} + {5'd0, w_nbad};

  always_comb begin
    w_err_nxt = r_err;
    if (w_in_err) w_err_nxt = (w_err_sum > 10'd255) ? 8'hFF : w_err_sum[7:0];
  end

  assign w_fatal_hit = w_in_err && (w_err_nxt >= LP_MAX_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase       <= PH_IDLE;
      r_phase_start <= 1'b0;
    end else begin
      r_phase       <= w_phase_nxt;
      r_phase_start <= (w_phase_nxt != r_phase);
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      PH_IDLE:    if (start) w_phase_nxt = PH_BUILD;
      PH_BUILD:   w_phase_nxt = w_fatal_hit ? PH_REPORT : PH_CONNECT;
      PH_CONNECT: w_phase_nxt = w_fatal_hit ? PH_REPORT : PH_RUN;
      PH_RUN: begin
        if (w_fatal_hit || w_timeout_hit)         w_phase_nxt = PH_REPORT;
        else if (w_all_zero_nxt && !w_any_raise)  w_phase_nxt = PH_DRAIN;
      end
      PH_DRAIN: begin
        if (w_fatal_hit || w_timeout_hit) w_phase_nxt = PH_REPORT;
        else if (w_any_raise)             w_phase_nxt = PH_RUN;
        else if (r_drain_left == 16'd0)   w_phase_nxt = PH_EXTRACT;
      end
      PH_EXTRACT: w_phase_nxt = PH_REPORT;
      PH_REPORT:  w_phase_nxt = PH_DONE;
      PH_DONE:    if (start) w_phase_nxt = PH_BUILD;
      default:    w_phase_nxt = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_AGENTS; i++) r_cnt[i] <= 4'd0;
      r_obj_active <= '0;
      r_err        <= 8'd0;
      r_timer      <= 32'd0;
      r_drain_left <= 16'd0;
      r_timeout    <= 1'b0;
      r_fatal      <= 1'b0;
      r_done       <= 1'b0;
    end else if (w_start_ok) begin
      for (int i = 0; i < NUM_AGENTS; i++) r_cnt[i] <= 4'd0;
      r_obj_active <= '0;
      r_err        <= 8'd0;
      r_timer      <= 32'd0;
      r_drain_left <= 16'd0;
      r_timeout    <= 1'b0;
      r_fatal      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_AGENTS; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_obj_active <= w_active_nxt;
      r_err        <= w_err_nxt;
      if (w_in_obj) r_timer <= w_timer_inc;
      // Drain timer reloads on every entry, so a RUN excursion restarts it in full.
      if ((w_phase_nxt == PH_DRAIN) && (r_phase != PH_DRAIN))
        r_drain_left <= LP_DRAIN_LOAD;
      else if ((r_phase == PH_DRAIN) && (r_drain_left != 16'd0))
        r_drain_left <= r_drain_left - 16'd1;
      if (w_timeout_hit)           r_timeout <= 1'b1;
      if (w_fatal_hit)             r_fatal   <= 1'b1;
      if (w_phase_nxt == PH_DONE)  r_done    <= 1'b1;
    end
  end

  assign phase       = r_phase;
  assign phase_start = r_phase_start;
  assign obj_active  = r_obj_active;
  assign err_count   = r_err;
  assign timeout     = r_timeout;
  assign fatal       = r_fatal;
  assign done        = r_done;

endmodule
